// File: rtl/lsu_axi_master.sv
// Load/store unit bus master: turns one core load/store request into a single
// AXI4-Lite read or write, handling lane steering, extension and error reporting.
module lsu_axi_master #(
   parameter int AXI_AWIDTH     = 4,
   parameter int AXI_DWIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                    AXI_ACLK,
   input  logic                    AXI_ARESETN,
   input  logic                    LSU_REQ,
   input  logic                    LSU_WE,
   input  logic [31:0]             LSU_ADDR,
   input  logic [2:0]              LSU_FUNCT3,
   input  logic [31:0]             LSU_WDATA,
   output logic                    LSU_BUSY,
   output logic                    LSU_DONE,
   output logic                    LSU_ERR,
   output logic [31:0]             LSU_RDATA,
   output logic [AXI_AWIDTH-1:0]   AXI_AWADDR,
   output logic                    AXI_AWVALID,
   input  logic                    AXI_AWREADY,
   output logic [AXI_DWIDTH-1:0]   AXI_WDATA,
   output logic [AXI_DWIDTH/8-1:0] AXI_WSTRB,
   output logic                    AXI_WVALID,
   input  logic                    AXI_WREADY,
   input  logic [1:0]              AXI_BRESP,
   input  logic                    AXI_BVALID,
   output logic                    AXI_BREADY,
   output logic [AXI_AWIDTH-1:0]   AXI_ARADDR,
   output logic                    AXI_ARVALID,
   input  logic                    AXI_ARREADY,
   input  logic [AXI_DWIDTH-1:0]   AXI_RDATA,
   input  logic [1:0]              AXI_RRESP,
   input  logic                    AXI_RVALID,
   output logic                    AXI_RREADY
);

   // Counter only needs to reach TIMEOUT_CYCLES-1; the abort fires on that cycle.
   localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

   typedef enum logic [2:0] {IDLE, CHECK, WRITE, WRESP, READ, FINISH} state_t;

   state_t                  state, state_next;
   logic                    we_q, err_q;
   logic [31:0]             addr_q, sdata_q, rdata_q;
   logic [2:0]              f3_q;
   logic [AXI_AWIDTH-1:0]   axi_addr_q;
   logic [AXI_DWIDTH-1:0]   wdata_q;
   logic [AXI_DWIDTH/8-1:0] wstrb_q;
   logic                    aw_done, w_done, b_done, ar_done;
   logic [CW-1:0]           cnt;

   logic        aw_hs, w_hs, b_hs, ar_hs, r_hs, aw_all, w_all, b_all, timeout_hit;
   logic        legal, misaligned, check_ok;
   logic [31:0] store_data, lane, load_ext;
   logic [3:0]  store_strb;
   logic        unused_addr_bits;

   assign unused_addr_bits = ^addr_q[31:AXI_AWIDTH+2];

   assign aw_hs  = AXI_AWVALID & AXI_AWREADY;
   assign w_hs   = AXI_WVALID & AXI_WREADY;
   assign b_hs   = AXI_BVALID & AXI_BREADY;
   assign ar_hs  = AXI_ARVALID & AXI_ARREADY;
   assign r_hs   = AXI_RVALID & AXI_RREADY;
   assign aw_all = aw_done | aw_hs;
   assign w_all  = w_done | w_hs;
   assign b_all  = b_done | b_hs;
   assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == TO_LAST);

   // Request legality, store lane steering and load extraction from latched request.
   always_comb begin
      legal      = LSU_WE ? 1'b0 : 1'b0;
      legal      = we_q ? (f3_q inside {3'b000, 3'b001, 3'b010})
                        : (f3_q inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
      misaligned = ((f3_q[1:0] == 2'b01) && addr_q[0]) ||
                   ((f3_q == 3'b010) && (addr_q[1:0] != 2'b00));
      check_ok   = legal && !misaligned;
      case (f3_q[1:0])
         2'b00:   begin store_data = {4{sdata_q[7:0]}};  store_strb = 4'b0001 << addr_q[1:0]; end
         2'b01:   begin store_data = {2{sdata_q[15:0]}}; store_strb = 4'b0011 << {addr_q[1], 1'b0}; end
         default: begin store_data = sdata_q;            store_strb = 4'b1111; end
      endcase
      lane = AXI_RDATA >> {addr_q[1:0], 3'b000};
      case (f3_q)
         3'b000:  load_ext = {{24{lane[7]}}, lane[7:0]};
         3'b001:  load_ext = {{16{lane[15]}}, lane[15:0]};
         3'b100:  load_ext = {24'd0, lane[7:0]};
         3'b101:  load_ext = {16'd0, lane[15:0]};
         default: load_ext = lane;
      endcase
   end

   // State register.
   always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
      if (!AXI_ARESETN) state <= IDLE;
      else              state <= state_next;
   end

   // Next-state decision; a bus wait ends on its handshake or on timeout.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:   if (LSU_REQ) state_next = CHECK;
         CHECK:  state_next = !check_ok ? FINISH : (we_q ? WRITE : READ);
         WRITE:  begin
            if (aw_all && w_all && b_all) state_next = FINISH;
            else if (aw_all && w_all)     state_next = WRESP;
            else if (timeout_hit)         state_next = FINISH;
         end
         WRESP:  if (b_hs || timeout_hit) state_next = FINISH;
         READ:   if (r_hs || timeout_hit) state_next = FINISH;
         FINISH: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Outputs decoded from state; VALIDs drop individually once their handshake is recorded.
   always_comb begin
      LSU_BUSY    = (state != IDLE);
      LSU_DONE    = (state == FINISH);
      LSU_ERR     = (state == FINISH) && err_q;
      LSU_RDATA   = rdata_q;
      AXI_AWADDR  = axi_addr_q;
      AXI_ARADDR  = axi_addr_q;
      AXI_WDATA   = wdata_q;
      AXI_WSTRB   = wstrb_q;
      AXI_AWVALID = (state == WRITE) && !aw_done;
      AXI_WVALID  = (state == WRITE) && !w_done;
      AXI_BREADY  = (state == WRITE) || (state == WRESP);
      AXI_ARVALID = (state == READ) && !ar_done;
      AXI_RREADY  = (state == READ);
   end

   // Request capture, handshake bookkeeping, error/result capture and wait counter.
   always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
      if (!AXI_ARESETN) begin
         we_q <= 1'b0; err_q <= 1'b0; addr_q <= '0; sdata_q <= '0; rdata_q <= '0;
         f3_q <= '0; axi_addr_q <= '0; wdata_q <= '0; wstrb_q <= '0;
         aw_done <= 1'b0; w_done <= 1'b0; b_done <= 1'b0; ar_done <= 1'b0;
         cnt <= '0;
      end else begin
         if (state_next != state) cnt <= '0;
         else if (state == WRITE || state == WRESP || state == READ) cnt <= cnt + 1'b1;
         case (state)
            IDLE: if (LSU_REQ) begin
               we_q <= LSU_WE; addr_q <= LSU_ADDR; f3_q <= LSU_FUNCT3; sdata_q <= LSU_WDATA;
            end
            CHECK: begin
               err_q   <= !check_ok;
               aw_done <= 1'b0; w_done <= 1'b0; b_done <= 1'b0; ar_done <= 1'b0;
               if (check_ok) axi_addr_q <= addr_q[AXI_AWIDTH+1:2];
               if (check_ok && we_q) begin
                  wdata_q <= store_data;
                  wstrb_q <= store_strb;
               end
               // A rejected load still reports a zero result alongside DONE.
               if (!check_ok && !we_q) rdata_q <= '0;
            end
            WRITE: begin
               if (aw_hs) aw_done <= 1'b1;
               if (w_hs)  w_done  <= 1'b1;
               if (b_hs) begin
                  b_done <= 1'b1;
                  err_q  <= (AXI_BRESP != 2'b00);
               end
               if (!(aw_all && w_all) && timeout_hit) err_q <= 1'b1;
            end
            WRESP: begin
               if (b_hs)             err_q <= (AXI_BRESP != 2'b00);
               else if (timeout_hit) err_q <= 1'b1;
            end
            READ: begin
               if (ar_hs) ar_done <= 1'b1;
               if (r_hs) begin
                  err_q   <= (AXI_RRESP != 2'b00);
                  rdata_q <= (AXI_RRESP != 2'b00) ? 32'd0 : load_ext;
               end else if (timeout_hit) begin
                  err_q   <= 1'b1;
                  rdata_q <= '0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_axi_master.sv
// Directed bench for lsu_axi_master: hand-driven AXI slave responses, checked at negedges.
module tb_lsu_axi_master;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req, we;
   logic [31:0] addr, wdata_in;
   logic [2:0]  f3;
   logic        busy, done, err;
   logic [31:0] lsu_rdata;
   logic [3:0]  awaddr, araddr;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rvalid, rready;
   logic [31:0] wdata, rdata;
   logic [3:0]  wstrb;
   logic [1:0]  bresp, rresp;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   lsu_axi_master #(.AXI_AWIDTH(4), .AXI_DWIDTH(32), .TIMEOUT_CYCLES(8)) dut (
      .AXI_ACLK(clk), .AXI_ARESETN(rst_n),
      .LSU_REQ(req), .LSU_WE(we), .LSU_ADDR(addr), .LSU_FUNCT3(f3), .LSU_WDATA(wdata_in),
      .LSU_BUSY(busy), .LSU_DONE(done), .LSU_ERR(err), .LSU_RDATA(lsu_rdata),
      .AXI_AWADDR(awaddr), .AXI_AWVALID(awvalid), .AXI_AWREADY(awready),
      .AXI_WDATA(wdata), .AXI_WSTRB(wstrb), .AXI_WVALID(wvalid), .AXI_WREADY(wready),
      .AXI_BRESP(bresp), .AXI_BVALID(bvalid), .AXI_BREADY(bready),
      .AXI_ARADDR(araddr), .AXI_ARVALID(arvalid), .AXI_ARREADY(arready),
      .AXI_RDATA(rdata), .AXI_RRESP(rresp), .AXI_RVALID(rvalid), .AXI_RREADY(rready)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   // Present a request for one cycle; returns at the negedge where the DUT is in CHECK.
   task automatic issue(input logic w, input logic [31:0] a, input logic [2:0] f, input logic [31:0] d);
      req = 1'b1; we = w; addr = a; f3 = f; wdata_in = d;
      @(negedge clk);
      req = 1'b0;
      chk("busy_after_req", {31'd0, busy}, 32'd1);
   endtask

   task automatic write_txn(input string tag, input logic [3:0] exp_awaddr, input logic [3:0] exp_strb,
                            input logic [31:0] exp_wd, input int w_lag, input logic [1:0] resp,
                            input logic exp_err);
      @(negedge clk);
      chk({tag, "_aw_w_valid"}, {30'd0, awvalid, wvalid}, 32'd3);
      chk({tag, "_awaddr"}, {28'd0, awaddr}, {28'd0, exp_awaddr});
      chk({tag, "_wstrb"}, {28'd0, wstrb}, {28'd0, exp_strb});
      chk({tag, "_wdata"}, wdata, exp_wd);
      chk({tag, "_bready"}, {31'd0, bready}, 32'd1);
      awready = 1'b1; wready = (w_lag == 0);
      @(negedge clk);
      awready = 1'b0;
      for (int i = 1; i <= w_lag; i++) begin
         chk({tag, "_aw_dropped_w_held"}, {30'd0, awvalid, wvalid}, 32'd1);
         if (i == w_lag) wready = 1'b1;
         @(negedge clk);
      end
      wready = 1'b0;
      chk({tag, "_wresp_valids"}, {29'd0, awvalid, wvalid, bready}, 32'd1);
      chk({tag, "_no_early_done"}, {31'd0, done}, 32'd0);
      bvalid = 1'b1; bresp = resp;
      @(negedge clk);
      bvalid = 1'b0; bresp = 2'b00;
      chk({tag, "_done_err_busy"}, {29'd0, done, err, busy}, {29'd0, 1'b1, exp_err, 1'b1});
      @(negedge clk);
      chk({tag, "_idle_after"}, {30'd0, done, busy}, 32'd0);
   endtask

   task automatic read_txn(input string tag, input logic [3:0] exp_araddr, input logic [31:0] rd,
                           input logic [1:0] resp, input logic [31:0] exp_rd, input logic exp_err);
      @(negedge clk);
      chk({tag, "_ar_r"}, {30'd0, arvalid, rready}, 32'd3);
      chk({tag, "_araddr"}, {28'd0, araddr}, {28'd0, exp_araddr});
      arready = 1'b1;
      @(negedge clk);
      arready = 1'b0;
      chk({tag, "_ar_dropped"}, {30'd0, arvalid, rready}, 32'd1);
      rvalid = 1'b1; rdata = rd; rresp = resp;
      @(negedge clk);
      rvalid = 1'b0; rresp = 2'b00;
      chk({tag, "_done_err"}, {30'd0, done, err}, {30'd0, 1'b1, exp_err});
      chk({tag, "_rdata"}, lsu_rdata, exp_rd);
      chk({tag, "_rready_low"}, {31'd0, rready}, 32'd0);
      @(negedge clk);
      chk({tag, "_done_once"}, {30'd0, done, busy}, 32'd0);
      chk({tag, "_rdata_hold"}, lsu_rdata, exp_rd);
   endtask

   task automatic bad_req(input string tag, input logic w, input logic [31:0] a, input logic [2:0] f);
      issue(w, a, f, 32'h1234_5678);
      chk({tag, "_no_bus_check"}, {29'd0, awvalid, wvalid, arvalid}, 32'd0);
      @(negedge clk);
      chk({tag, "_no_bus_finish"}, {29'd0, awvalid, wvalid, arvalid}, 32'd0);
      chk({tag, "_done_err"}, {30'd0, done, err}, 32'd3);
      @(negedge clk);
      chk({tag, "_idle_after"}, {30'd0, done, busy}, 32'd0);
   endtask

   // Watchdog so the run always ends.
   initial begin
      #100000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; req = 1'b0; we = 1'b0; addr = '0; f3 = '0; wdata_in = '0;
      awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
      arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00;
      repeat (2) @(negedge clk);
      chk("reset_ctrl", {24'd0, busy, done, err, awvalid, wvalid, bready, arvalid, rready}, 32'd0);
      chk("reset_rdata", lsu_rdata, 32'd0);
      chk("reset_addr", {24'd0, awaddr, araddr}, 32'd0);
      chk("reset_wdata_wstrb", wdata | {28'd0, wstrb}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      issue(1'b1, 32'h8, 3'b010, 32'hCAFE_BABE);
      write_txn("sw", 4'd2, 4'b1111, 32'hCAFE_BABE, 0, 2'b00, 1'b0);
      issue(1'b1, 32'h7, 3'b000, 32'h0000_00A5);
      write_txn("sb", 4'd1, 4'b1000, 32'hA5A5_A5A5, 0, 2'b00, 1'b0);
      issue(1'b0, 32'h7, 3'b000, 32'h0);
      read_txn("lb", 4'd1, 32'hA500_0000, 2'b00, 32'hFFFF_FFA5, 1'b0);
      issue(1'b0, 32'h7, 3'b100, 32'h0);
      read_txn("lbu", 4'd1, 32'hA500_0000, 2'b00, 32'h0000_00A5, 1'b0);
      issue(1'b0, 32'h2, 3'b001, 32'h0);
      read_txn("lh", 4'd0, 32'h8001_1234, 2'b00, 32'hFFFF_8001, 1'b0);
      issue(1'b0, 32'h0, 3'b101, 32'h0);
      read_txn("lhu", 4'd0, 32'h8001_1234, 2'b00, 32'h0000_1234, 1'b0);
      issue(1'b1, 32'h2, 3'b001, 32'h0000_BEEF);
      write_txn("sh_slverr", 4'd0, 4'b1100, 32'hBEEF_BEEF, 3, 2'b10, 1'b1);
      issue(1'b0, 32'hC, 3'b010, 32'h0);
      read_txn("lw_rresp", 4'd3, 32'h1234_5678, 2'b11, 32'h0, 1'b1);
      issue(1'b0, 32'h4, 3'b010, 32'h0);
      read_txn("lw", 4'd1, 32'hDEAD_BEEF, 2'b00, 32'hDEAD_BEEF, 1'b0);

      // Asynchronous reset in the middle of a read.
      issue(1'b0, 32'h0, 3'b010, 32'h0);
      @(negedge clk);
      chk("rst_mid_arvalid_before", {31'd0, arvalid}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_mid_ctrl", {29'd0, arvalid, rready, busy}, 32'd0);
      chk("rst_mid_rdata", lsu_rdata, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      issue(1'b0, 32'h8, 3'b010, 32'h0);
      read_txn("lw2", 4'd2, 32'h0BAD_F00D, 2'b00, 32'h0BAD_F00D, 1'b0);

      // Slave never accepts AR: abort after 8 wait cycles.
      issue(1'b0, 32'h4, 3'b010, 32'h0);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("to_arvalid_held", {31'd0, arvalid}, 32'd1);
      end
      @(negedge clk);
      chk("to_dropped", {30'd0, arvalid, rready}, 32'd0);
      chk("to_done_err", {30'd0, done, err}, 32'd3);
      chk("to_rdata", lsu_rdata, 32'd0);
      @(negedge clk);
      rvalid = 1'b1; rdata = 32'hFFFF_FFFF;
      chk("late_r_rready", {31'd0, rready}, 32'd0);
      @(negedge clk);
      rvalid = 1'b0;
      chk("late_r_ignored", {30'd0, done, busy}, 32'd0);
      chk("late_r_rdata", lsu_rdata, 32'd0);

      bad_req("lw_mis", 1'b0, 32'h6, 3'b010);
      bad_req("sh_mis", 1'b1, 32'h3, 3'b001);
      bad_req("st_f3_100", 1'b1, 32'h0, 3'b100);
      bad_req("ld_f3_011", 1'b0, 32'h0, 3'b011);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
